// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its interval timer.
package traffic_pkg;

  localparam int N_TIMER = 11;
  localparam int TS_DEF  = 5;
  localparam int TL_DEF  = 25;

  localparam logic CFG_SEL_TS = 1'b0;
  localparam logic CFG_SEL_TL = 1'b1;

  typedef enum logic {
    T_RUN = 1'b0,
    T_SAT = 1'b1
  } timer_state_t;

endpackage

// File: rtl/phase_interval_timer_if.sv
// Start/timeout handshake and limit-programming port of the interval timer.
interface phase_interval_timer_if #(
  parameter int N = traffic_pkg::N_TIMER
) ();

  logic         st;
  logic         tick_en;
  logic         cfg_wr;
  logic         cfg_sel;
  logic [N-1:0] cfg_data;
  logic         cfg_ack;
  logic         ts;
  logic         tl;
  logic         timeoff;
  logic [N-1:0] timing;

  modport master (
    output st, tick_en, cfg_wr, cfg_sel, cfg_data,
    input  cfg_ack, ts, tl, timeoff, timing
  );

  modport slave (
    input  st, tick_en, cfg_wr, cfg_sel, cfg_data,
    output cfg_ack, ts, tl, timeoff, timing
  );

endinterface

// File: rtl/sat_counter.sv
// N-bit up-counter with synchronous clear (priority over enable) that sticks at all-ones.
module sat_counter
  import traffic_pkg::*;
#(
  parameter int N = N_TIMER
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] count,
  output logic         sat
);

  localparam logic [N-1:0] COUNT_MAX = {N{1'b1}};

  timer_state_t state, state_nxt;
  logic [N-1:0] count_nxt;
  logic [N-1:0] count_inc;

  assign count_inc = count + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= T_RUN;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // NOTE: defaults come first so no path leaves a variable unassigned (no latch).
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    if (clr) begin
      state_nxt = T_RUN;
      count_nxt = '0;
    end else begin
      unique case (state)
        T_RUN: begin
          if (en) begin
            count_nxt = count_inc;
            if (count_inc == COUNT_MAX) state_nxt = T_SAT;
          end
        end
        T_SAT: begin
          count_nxt = COUNT_MAX;
        end
        default: begin
          state_nxt = T_RUN;
          count_nxt = '0;
        end
      endcase
    end
  end

  assign sat = (state == T_SAT);

endmodule

// File: rtl/phase_interval_timer.sv
// Interval timer answering the controller's st pulse with ts/tl/timeoff expiry flags.
module phase_interval_timer
  import traffic_pkg::*;
#(
  parameter int N      = traffic_pkg::N_TIMER,
  parameter int TS_DEF = traffic_pkg::TS_DEF,
  parameter int TL_DEF = traffic_pkg::TL_DEF
) (
  input  logic                   clk,
  input  logic                   reset_n,
  phase_interval_timer_if.slave  bus
);

  localparam logic [N-1:0] TS_INIT = N'(TS_DEF);
  localparam logic [N-1:0] TL_INIT = N'(TL_DEF);

  logic [N-1:0] count;
  logic         sat;
  logic [N-1:0] shadow_ts, shadow_tl;
  logic [N-1:0] active_ts, active_tl;
  logic         cfg_ack;

  sat_counter #(.N(N)) u_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (bus.st),
    .en      (bus.tick_en),
    .count   (count),
    .sat     (sat)
  );

  // Software writes land in the shadow copy; the running interval keeps the
  // active copy, refreshed only by st. A simultaneous write therefore misses
  // this st and takes effect at the next one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_ts <= TS_INIT;
      shadow_tl <= TL_INIT;
      active_ts <= TS_INIT;
      active_tl <= TL_INIT;
      cfg_ack   <= 1'b0;
    end else begin
      cfg_ack <= bus.cfg_wr;
      if (bus.cfg_wr) begin
        if (bus.cfg_sel == CFG_SEL_TL) shadow_tl <= bus.cfg_data;
        else                           shadow_ts <= bus.cfg_data;
      end
      if (bus.st) begin
        active_ts <= shadow_ts;
        active_tl <= shadow_tl;
      end
    end
  end

  assign bus.ts      = (count >= active_ts);
  assign bus.tl      = (count >= active_tl);
  assign bus.timeoff = sat;
  assign bus.timing  = count;
  assign bus.cfg_ack = cfg_ack;

endmodule

// File: tb/tb_phase_interval_timer.sv
// Directed bench for phase_interval_timer: default timer (N=11) plus a 4-bit saturation instance.
module tb_phase_interval_timer;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic reset4_n;

  int n_checks = 0;
  int n_pass   = 0;

  phase_interval_timer_if #(.N(N_TIMER)) bus ();
  phase_interval_timer_if #(.N(4))       bus4 ();

  phase_interval_timer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  phase_interval_timer #(.N(4), .TS_DEF(15), .TL_DEF(15)) dut4 (
    .clk     (clk),
    .reset_n (reset4_n),
    .bus     (bus4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_st();
    bus.st = 1'b1;
    tick_n(1);
    bus.st = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    reset4_n     = 1'b0;
    bus.st       = 1'b0;
    bus.tick_en  = 1'b1;
    bus.cfg_wr   = 1'b0;
    bus.cfg_sel  = CFG_SEL_TS;
    bus.cfg_data = '0;
    bus4.st       = 1'b0;
    bus4.tick_en  = 1'b0;
    bus4.cfg_wr   = 1'b0;
    bus4.cfg_sel  = CFG_SEL_TS;
    bus4.cfg_data = '0;

    // 1. Reset state, then free-run with default limits 5/25.
    tick_n(2);
    check("rst_timing",  32'(bus.timing), 0);
    check("rst_ts",      32'(bus.ts), 0);
    check("rst_tl",      32'(bus.tl), 0);
    check("rst_timeoff", 32'(bus.timeoff), 0);
    check("rst_ack",     32'(bus.cfg_ack), 0);
    reset_n = 1'b1;
    tick_n(4);
    check("t1_timing4", 32'(bus.timing), 4);
    check("t1_ts_at4",  32'(bus.ts), 0);
    tick_n(1);
    check("t1_ts_at5",  32'(bus.ts), 1);
    tick_n(19);
    check("t1_tl_at24", 32'(bus.tl), 0);
    tick_n(1);
    check("t1_tl_at25", 32'(bus.tl), 1);
    check("t1_timing25", 32'(bus.timing), 25);

    // 2. st at count 17 clears without also incrementing.
    pulse_st();
    tick_n(17);
    check("t2_timing17", 32'(bus.timing), 17);
    pulse_st();
    check("t2_timing0", 32'(bus.timing), 0);
    check("t2_ts_clr",  32'(bus.ts), 0);
    check("t2_tl_clr",  32'(bus.tl), 0);
    tick_n(4);
    check("t2_ts_at4",  32'(bus.ts), 0);
    tick_n(1);
    check("t2_ts_at5",  32'(bus.ts), 1);

    // 3. Short limit written mid-interval only applies after the next st.
    pulse_st();
    tick_n(1);
    bus.cfg_wr   = 1'b1;
    bus.cfg_sel  = CFG_SEL_TS;
    bus.cfg_data = 11'd3;
    tick_n(1);
    bus.cfg_wr = 1'b0;
    check("t3_ack_hi",  32'(bus.cfg_ack), 1);
    check("t3_timing2", 32'(bus.timing), 2);
    tick_n(1);
    check("t3_ack_lo",  32'(bus.cfg_ack), 0);
    check("t3_ts_old3", 32'(bus.ts), 0);
    tick_n(1);
    check("t3_ts_old4", 32'(bus.ts), 0);
    tick_n(1);
    check("t3_ts_old5", 32'(bus.ts), 1);
    pulse_st();
    tick_n(2);
    check("t3_ts_new2", 32'(bus.ts), 0);
    tick_n(1);
    check("t3_ts_new3", 32'(bus.ts), 1);

    // 4. Long-limit write coinciding with st: old limit this interval.
    bus.cfg_wr   = 1'b1;
    bus.cfg_sel  = CFG_SEL_TL;
    bus.cfg_data = 11'd8;
    bus.st       = 1'b1;
    tick_n(1);
    bus.cfg_wr = 1'b0;
    bus.st     = 1'b0;
    check("t4_ack",     32'(bus.cfg_ack), 1);
    check("t4_timing0", 32'(bus.timing), 0);
    tick_n(8);
    check("t4_tl_old8", 32'(bus.tl), 0);
    bus.tick_en = 1'b0;
    tick_n(3);
    check("t4_hold",    32'(bus.timing), 8);
    bus.tick_en = 1'b1;
    tick_n(16);
    check("t4_tl_old24", 32'(bus.tl), 0);
    tick_n(1);
    check("t4_tl_old25", 32'(bus.tl), 1);
    pulse_st();
    tick_n(7);
    check("t4_tl_new7", 32'(bus.tl), 0);
    tick_n(1);
    check("t4_tl_new8", 32'(bus.tl), 1);

    // 6. Asynchronous reset mid-count, checked before any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_timing", 32'(bus.timing), 0);
    check("t6_ts",     32'(bus.ts), 0);
    check("t6_tl",     32'(bus.tl), 0);
    check("t6_ack",    32'(bus.cfg_ack), 0);
    tick_n(1);
    reset_n = 1'b1;
    tick_n(4);
    check("t6_ts_def4",  32'(bus.ts), 0);
    tick_n(1);
    check("t6_ts_def5",  32'(bus.ts), 1);
    tick_n(19);
    check("t6_tl_def24", 32'(bus.tl), 0);
    tick_n(1);
    check("t6_tl_def25", 32'(bus.tl), 1);

    // 5. 4-bit instance with limits 15/15 saturates and holds.
    reset4_n     = 1'b1;
    bus4.tick_en = 1'b1;
    tick_n(14);
    check("t5_timing14", 32'(bus4.timing), 14);
    check("t5_off14",    32'(bus4.timeoff), 0);
    check("t5_ts14",     32'(bus4.ts), 0);
    tick_n(1);
    check("t5_timing15", 32'(bus4.timing), 15);
    check("t5_off15",    32'(bus4.timeoff), 1);
    check("t5_ts15",     32'(bus4.ts), 1);
    check("t5_tl15",     32'(bus4.tl), 1);
    tick_n(3);
    check("t5_held",     32'(bus4.timing), 15);
    check("t5_off_held", 32'(bus4.timeoff), 1);
    bus4.st = 1'b1;
    tick_n(1);
    bus4.st = 1'b0;
    check("t5_st_timing", 32'(bus4.timing), 0);
    check("t5_st_off",    32'(bus4.timeoff), 0);
    check("t5_st_ts",     32'(bus4.ts), 0);
    check("t5_st_tl",     32'(bus4.tl), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
